// File: rtl/debug_uart_pkg.sv
// Shared types and frame constants for the debug UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package debug_uart_pkg;

    // Transmit sequencer states, one per segment of an 8N1 frame.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Frame shape: 8 data bits, no parity, one stop bit.
    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/debug_uart_tx_if.sv
// Byte-push and status bundle between the CPU debug port and the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: none on the wire; the producer watches fifo_full/overflow itself.
//
// Signals:
//   tx_Data      byte to send, sampled when tx_DataValid is high
//   tx_DataValid one byte pushed per cycle held high
//   overflow_clr clears the sticky overflow flag
//   busy         frame on the line or bytes still buffered
//   fifo_full    buffer holds its full depth of bytes
//   overflow     sticky: at least one byte was dropped
interface debug_uart_tx_if;
    logic [7:0] tx_Data;
    logic       tx_DataValid;
    logic       overflow_clr;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    // Core side drives bytes and reads status.
    modport master (
        output tx_Data,
        output tx_DataValid,
        output overflow_clr,
        input  busy,
        input  fifo_full,
        input  overflow
    );

    // Transmitter side consumes bytes and reports status.
    modport slave (
        input  tx_Data,
        input  tx_DataValid,
        input  overflow_clr,
        output busy,
        output fifo_full,
        output overflow
    );
endinterface

// File: rtl/debug_uart_tx_sync_fifo.sv
// Generic single-clock FIFO, power-of-two depth, registered pointers and count.
// Latency: a pushed entry is visible on pop_dat/empty the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens on the same edge.
//
// Ports: clk, resetn (async active-low); push/push_dat write side;
//        pop/pop_dat read side (pop_dat is the head entry, valid when !empty);
//        full, empty, count status.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A pop frees the head slot on the same edge, so a full FIFO can still
    // take a push then; the write lands in the slot being vacated.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly PTR_W bits, so they wrap on their own.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Buffers CPU debug bytes and serialises them as 8N1 UART frames on uart_txd.
// Latency: byte pushed into an empty idle buffer -> start bit on the 2nd edge after the push.
// Backpressure: none to the core; bytes arriving with the buffer full are dropped and flag overflow.
//
// Ports: clk, resetn (async active-low); dbg (slave modport: tx_Data, tx_DataValid,
//        overflow_clr in; busy, fifo_full, overflow out); uart_txd serial out, idle high.
module debug_uart_tx
    import debug_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              resetn,
    debug_uart_tx_if.slave    dbg,
    output logic              uart_txd
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int                LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e        state,    state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]       bit_idx,  bit_idx_nxt;
    logic [7:0]       shift,    shift_nxt;
    logic             txd_q,    txd_nxt;
    logic             ovf_q;

    logic             fifo_pop;
    logic [7:0]       fifo_dat;
    logic             fifo_is_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_count;
    logic             bit_end;
    logic             drop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (dbg.tx_DataValid),
        .push_dat (dbg.tx_Data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_is_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bit_end = (baud_cnt == CNT_LAST);

    // Next-state, counters and the line level for the *current* state.
    // The line level is registered one edge later, which yields the
    // two-edge push-to-start-bit latency and a flop-driven pin.
    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        fifo_pop    = 1'b0;
        txd_nxt     = IDLE_LEVEL;

        case (state)
            ST_IDLE: begin
                txd_nxt = IDLE_LEVEL;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_dat;
                    baud_nxt  = '0;
                    state_nxt = ST_START;
                end
            end

            ST_START: begin
                txd_nxt = START_LEVEL;
                if (bit_end) begin
                    baud_nxt    = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = ST_DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            ST_DATA: begin
                // LSB first: shift[0] is always the bit on the line.
                txd_nxt = shift[0];
                if (bit_end) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            ST_STOP: begin
                txd_nxt = STOP_LEVEL;
                if (bit_end) begin
                    baud_nxt = '0;
                    // Chain straight into the next frame when more bytes wait,
                    // so consecutive frames have no idle gap between them.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_nxt = fifo_dat;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                baud_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd_q    <= IDLE_LEVEL;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
            txd_q    <= txd_nxt;
        end
    end

    // A byte is lost only when the buffer is full and nothing leaves it
    // on the same edge. A drop outranks a clear arriving together.
    assign drop = dbg.tx_DataValid & fifo_is_full & ~fifo_pop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (dbg.overflow_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign uart_txd      = txd_q;
    assign dbg.overflow  = ovf_q;
    assign dbg.fifo_full = (fifo_count == LVL_W'(FIFO_DEPTH));
    assign dbg.busy      = (state != ST_IDLE) | ~fifo_empty;

endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
- Consumer end of the CPU debug byte stream.
- Accepts bytes presented on tx_Data/tx_DataValid by the core.
- Buffers them in a small FIFO.
- Serialises each byte as an 8N1 UART frame on a single output pin.
- Instantiated at board top level beside the CPU, so debug traffic reaches a host terminal without stalling the core.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 16, byte entries in the buffer; power of two, >= 2

Ports:
clk           input   1  system clock; all logic on rising edge
resetn        input   1  asynchronous active-low reset
tx_Data       input   8  byte to transmit; sampled when tx_DataValid = 1
tx_DataValid  input   1  write strobe; each cycle high pushes one byte
overflow_clr  input   1  synchronous clear of the overflow flag
uart_txd      output  1  serial line; idle high
busy          output  1  high while a frame is on the line or the FIFO is non-empty
fifo_full     output  1  FIFO holds FIFO_DEPTH bytes
overflow      output  1  sticky; set when a byte was dropped

Behaviour:
- Reset (asynchronous assert, synchronous-release input assumed external):
  - uart_txd = 1, busy = 0, fifo_full = 0, overflow = 0.
  - FIFO empty, baud counter = 0, bit index = 0, FSM = IDLE.
  - Reset mid-frame aborts the frame. uart_txd returns high immediately on assertion. Buffered bytes are discarded.
- Push:
  - tx_DataValid = 1 on a rising edge writes tx_Data if the FIFO is not full, or if a pop occurs in the same cycle (count unchanged).
  - Otherwise the byte is dropped and overflow is set on that edge.
  - overflow_clr = 1 clears overflow. If a drop and a clear coincide, the set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_txd = 1. If the FIFO is non-empty, pop into shift register and go to START; baud counter = 0.
  - START: uart_txd = 0 for CLKS_PER_BIT cycles, then DATA with bit index = 0.
  - DATA: uart_txd = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. Shift right and increment index at bit end. After bit 7, go to STOP.
  - STOP: uart_txd = 1 for CLKS_PER_BIT cycles. On the final stop cycle:
    - FIFO non-empty: pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise: go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary. Width is clog2(CLKS_PER_BIT).
- Latency:
  - Push into an empty FIFO while IDLE: uart_txd falls on the 2nd rising edge after the push edge.
  - No combinational bypass from tx_Data to uart_txd.
  - uart_txd is driven from a flop (glitch-free).
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- busy = (state != IDLE) | ~fifo_empty. It is registered-derived and never glitches.
- Pointer/count rules:
  - Read/write pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
  - Count is clog2(FIFO_DEPTH)+1 bits.
  - fifo_full = (count == FIFO_DEPTH).
- tx_DataValid is not edge-detected. A producer holding it high for N cycles enqueues N copies.

Decomposition:
- Package debug_uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Frame constants: DATA_BITS = 8, STOP_LEVEL = 1, IDLE_LEVEL = 1.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/count, with same-cycle push+pop allowed when full.
- debug_uart_tx holds the FSM, baud counter, shift register and overflow flag.

Test Plan (CLKS_PER_BIT = 4, FIFO_DEPTH = 4):
- Single byte 0x55 pushed one cycle:
  - uart_txd low 2 edges later, for 4 cycles.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles.
  - busy falls after 40 cycles; total 42 edges from the push.
- Bytes 0xA5, 0x3C on consecutive cycles:
  - Two frames back-to-back; the second start bit begins the cycle after the first stop bit ends.
  - Decoded 0xA5 then 0x3C; 80 cycles of activity.
- Push 6 bytes 0x01..0x06 on consecutive cycles:
  - The first is popped on push+1, so 0x01..0x05 are accepted; 0x06 is dropped.
  - fifo_full = 1 on push of 0x05; overflow = 1 on the 6th push.
  - Frames 0x01..0x05 only; overflow_clr pulse then clears overflow.
- FIFO full and a pop coincide with a push (0x77) on the STOP→START edge: 0x77 is accepted, overflow stays 0, and it is transmitted last.
- Assert resetn = 0 mid-DATA of 0xFF with 2 bytes queued:
  - uart_txd = 1 and busy = 0 immediately.
  - After release: line idle, no frames emitted.
- tx_DataValid high 3 cycles with tx_Data = 0x41: three identical 0x41 frames back-to-back.
